// File: rtl/rv32i_pkg.sv
// Shared RV32I constants: immediate-format selects, major opcodes, fetch entry layout.
// Latency: none (types, constants and a pure combinational predecode helper).
// Backpressure: not applicable.
package rv32i_pkg;

  // Immediate-format select shared by the fetch predecoder and the sign extender
  typedef enum logic [2:0] {
    EXT_I = 3'b000,
    EXT_S = 3'b001,
    EXT_B = 3'b010,
    EXT_U = 3'b011,
    EXT_J = 3'b100
  } ext_src_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam int FETCH_FIFO_DEPTH = 2;

  // One buffered instruction: word, its address and the predecoded fields
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    ext_src_e    ext_src;
    logic        illegal;
  } fetch_entry_t;

  // Classify the opcode so decode gets the immediate format without its own lookup
  function automatic fetch_entry_t predecode(input logic [31:0] instr, input logic [31:0] pc);
    fetch_entry_t e;
    e.instr   = instr;
    e.pc      = pc;
    e.ext_src = EXT_I;
    e.illegal = 1'b0;
    case (instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR, OP_REG: e.ext_src = EXT_I;
      OP_STORE:                         e.ext_src = EXT_S;
      OP_BRANCH:                        e.ext_src = EXT_B;
      OP_LUI, OP_AUIPC:                 e.ext_src = EXT_U;
      OP_JAL:                           e.ext_src = EXT_J;
      default:                          e.illegal = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry buffer of predecoded fetch entries with occupancy count and flush.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: none internally; the producer must never push when full.
module fetch_fifo
  import rv32i_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  fetch_entry_t i_push_dat,
  input  logic         i_pop,
  input  logic         i_flush,
  output fetch_entry_t o_head_dat,
  output logic [1:0]   o_count
);

  fetch_entry_t r_mem [FETCH_FIFO_DEPTH];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;

  // Storage, pointers and count; flush empties the buffer and overrides push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FETCH_FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_count    = r_count;

endmodule

// File: rtl/instr_fetch.sv
// RV32I instruction fetch: single-outstanding imem requests, predecode, 2-deep output buffer.
// Latency: instruction presented on if_* the cycle after imem_rvalid; 1 instr/cycle sustained.
// Backpressure: id_ready=0 holds if_*; fetching stops once buffered + in-flight reaches 2.
module instr_fetch
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [2:0]  if_ExtendSrc,
  output logic        if_illegal
);

  logic [31:0]  r_pc;
  logic [31:0]  r_req_pc;
  logic         r_outstanding;
  logic         r_kill;

  logic [1:0]   w_count;
  fetch_entry_t w_head;
  fetch_entry_t w_push_dat;
  logic         w_pop;
  logic         w_rsp;
  logic         w_accept;
  logic         w_room;
  logic         w_issue;
  logic         w_unused_redirect_lsbs;

  assign w_pop    = (w_count != 2'd0) && id_ready;
  assign w_rsp    = imem_rvalid && r_outstanding;
  // A response is kept only if it belongs to the current stream and no redirect is flushing
  assign w_accept = w_rsp && !r_kill && !redirect_valid;
  // In-flight request counts as an occupied slot, so a late return always fits
  assign w_room   = ({1'b0, w_count} + {2'b00, r_outstanding} - {2'b00, w_pop}) < 3'd2;
  // Gated by rst_n so no request escapes while reset is held
  assign w_issue  = rst_n && (!r_outstanding || imem_rvalid) && w_room && !redirect_valid;

  assign w_push_dat = predecode(imem_rdata, r_req_pc);
  assign w_unused_redirect_lsbs = ^redirect_pc[1:0];

  // Fetch PC: redirect retargets (word aligned), otherwise advance on each issued request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_req_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= {redirect_pc[31:2], 2'b00};
    end else if (w_issue) begin
      r_pc     <= r_pc + 32'd4;
      r_req_pc <= r_pc;
    end
  end

  // Outstanding/kill tracking: a request still in flight at redirect is marked for discard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= 1'b0;
      r_kill        <= 1'b0;
    end else if (redirect_valid) begin
      r_outstanding <= r_outstanding && !imem_rvalid;
      r_kill        <= r_outstanding && !imem_rvalid;
    end else begin
      if (w_issue)    r_outstanding <= 1'b1;
      else if (w_rsp) r_outstanding <= 1'b0;
      if (w_rsp)      r_kill        <= 1'b0;
    end
  end

  fetch_fifo u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_accept),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .i_flush    (redirect_valid),
    .o_head_dat (w_head),
    .o_count    (w_count)
  );

  assign imem_req     = w_issue;
  assign imem_addr    = r_pc;
  assign if_valid     = (w_count != 2'd0);
  assign if_instr     = w_head.instr;
  assign if_pc        = w_head.pc;
  assign if_ExtendSrc = w_head.ext_src;
  assign if_illegal   = w_head.illegal;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 imem_req  output  1  instruction memory read request, one beat.
REQ-005 imem_addr  output  32  word-aligned fetch address, valid while imem_req=1.
REQ-006 imem_rvalid  input  1  read data valid, at least 1 cycle after request, in request order.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 redirect_valid  input  1  branch/jump redirect strobe.
REQ-009 redirect_pc  input  32  redirect target.
REQ-010 id_ready  input  1  decode/extend stage accepts the current instruction.
REQ-011 if_valid  output  1  if_instr/if_pc/if_ExtendSrc hold a valid instruction.
REQ-012 if_instr  output  32  instruction word; bits [31:7] feed the sign extender.
REQ-013 if_pc  output  32  address of if_instr.
REQ-014 if_ExtendSrc  output  3  immediate-format select for the sign extender.
REQ-015 if_illegal  output  1  opcode not in the supported RV32I set.

Function
REQ-016 At most one imem request SHALL be outstanding.
REQ-017 Issue condition: imem_req=1 iff (no outstanding request or imem_rvalid=1 this cycle) and (fifo_count + outstanding - pop) < 2 and redirect_valid=0.
REQ-018 On an issued request, PC SHALL advance by 4 (unsigned 32-bit, 0xFFFF_FFFC wraps to 0).
REQ-019 The accepted response SHALL be written into a 2-entry FIFO with its PC and predecoded fields; if_valid asserts the following cycle. FIFO can never overflow under REQ-017.
REQ-020 Sustained throughput with a 1-cycle memory and id_ready=1 SHALL be one instruction per cycle.
REQ-021 Pop SHALL occur when if_valid=1 and id_ready=1; outputs hold stable while if_valid=1 and id_ready=0.
REQ-022 Predecode opcode [6:0]: 0010011/0000011/1100111 -> 3'b000 (I); 0100011 -> 3'b001 (S); 1100011 -> 3'b010 (B); 0110111/0010111 -> 3'b011 (U); 1101111 -> 3'b100 (J); 0110011 -> 3'b000; any other opcode -> 3'b000 with if_illegal=1.
REQ-023 On redirect_valid=1: FIFO flushed, PC <= {redirect_pc[31:2],2'b00}, imem_req=0 that cycle; fetching resumes the next cycle.
REQ-024 A response arriving in the redirect cycle SHALL be discarded.
REQ-025 If a request is outstanding and not returning in the redirect cycle, a kill flag SHALL be set; the next response is discarded, clears kill and outstanding, and no new request is issued until then.
REQ-026 Redirect simultaneous with pop: flush wins; the popped instruction is still consumed by downstream that cycle.
REQ-027 Repeated redirects on consecutive cycles: last target wins; at most one kill pending.

Reset
REQ-028 While rst_n=0: PC=RESET_PC, FIFO empty, outstanding=0, kill=0, imem_req=0, if_valid=0, if_instr=0, if_pc=0, if_ExtendSrc=3'b000, if_illegal=0.
REQ-029 Reset asserted mid-transaction SHALL abandon any outstanding request; a late imem_rvalid after reset release with no request issued SHALL be ignored.
REQ-030 First request SHALL issue in the first cycle after rst_n deasserts, addr=RESET_PC.

Structure
REQ-031 Shared package rv32i_pkg SHALL hold ExtendSrc encodings (I=000, S=001, B=010, U=011, J=100) and opcode constants; the sign extender and this block use the same constants.
REQ-032 The FIFO SHALL be a sub-module fetch_fifo (2 entries, width 32+32+3+1, count, push/pop/flush).

Verification
REQ-033 Reset release, 1-cycle memory returning 0x00000013 at every address, id_ready=1 -> requests at 0x0,0x4,0x8 on consecutive cycles; if_valid from cycle 2, if_pc 0x0,0x4,0x8, if_ExtendSrc=000.
REQ-034 id_ready=0 for 5 cycles -> at most 2 buffered, imem_req drops, if_pc held; on release pcs continue in order without loss or duplication.
REQ-035 Memory latency 3, redirect to 0x103 while request outstanding -> stale response dropped, next request addr=0x100, first if_pc=0x100.
REQ-036 Return 0x00000023, 0x00000063, 0x00000037, 0x0000006F, 0x0000007F -> if_ExtendSrc 001,010,011,100,000; if_illegal only on the last.
REQ-037 PC at 0xFFFF_FFFC -> next request addr=0x0000_0000.
REQ-038 rst_n pulsed low with a request outstanding -> all outputs at reset values asynchronously; first request after release at RESET_PC.
